// File: rtl/stoch_round_pkg.sv
// Shared definitions for the stochastic-rounding unit.
//   SR_RND_W     : width of the LFSR sample (and of the dropped fraction)
//   SR_IN_W_DEF  : default input word width
//   SR_OUT_W_DEF : default output word width
//   sr_sat_max() : largest positive value of a signed word of the given width
package stoch_round_pkg;

    localparam int unsigned SR_RND_W     = 7;
    localparam int unsigned SR_IN_W_DEF  = 16;
    localparam int unsigned SR_OUT_W_DEF = SR_IN_W_DEF - SR_RND_W;

    function automatic int unsigned sr_sat_max(input int unsigned out_w);
        return (32'd1 << (out_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/stoch_round_core.sv
// Combinational add / arithmetic-shift / positive-saturate datapath.
// Ports:
//   data  : signed input word (IN_W bits, SR_RND_W fractional bits)
//   rnd   : random sample added to the fraction before truncation
//   res_c : floor((data + rnd) / 2^SR_RND_W), clipped to the positive max
//   sat_c : result was clipped
module stoch_round_core
    import stoch_round_pkg::*;
#(
    parameter int unsigned IN_W  = SR_IN_W_DEF,
    parameter int unsigned OUT_W = SR_OUT_W_DEF
) (
    input  logic [IN_W-1:0]     data,
    input  logic [SR_RND_W-1:0] rnd,
    output logic [OUT_W-1:0]    res_c,
    output logic                sat_c
);

    localparam int unsigned SUM_W = IN_W + 1;
    localparam int unsigned Q_W   = SUM_W - SR_RND_W;
    localparam logic [Q_W-1:0]   SAT_MAX_Q   = Q_W'(sr_sat_max(OUT_W));
    localparam logic [OUT_W-1:0] SAT_MAX_OUT = OUT_W'(sr_sat_max(OUT_W));

    logic [SUM_W-1:0] sum;
    logic [Q_W-1:0]   q;
    logic             unused_frac;

    // One guard bit keeps the positive carry of (max + rnd) from wrapping.
    always_comb begin
        sum   = {data[IN_W-1], data} + SUM_W'(rnd);
        q     = sum[SUM_W-1:SR_RND_W];
        // rnd is never negative, so only the upper clamp can trigger.
        sat_c = !q[Q_W-1] && (q > SAT_MAX_Q);
        res_c = sat_c ? SAT_MAX_OUT : q[OUT_W-1:0];
    end

    assign unused_frac = ^sum[SR_RND_W-1:0];

endmodule

// File: rtl/stoch_round_unit.sv
// Stochastic-rounding narrowing stage with a 2-deep valid/ready pipeline.
// Stage 1 captures the word together with its LFSR sample; stage 2 holds
// the rounded, saturated result. Each accepted word advances the LFSR once.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready/in_data     : upstream handshake and signed word
//   rnd, rnd_en                   : LFSR sample and LFSR advance enable
//   out_valid/out_ready/out_data  : downstream handshake and result
//   out_sat                       : result was clipped
// Optional (SR_SAT_CNT_EN defined):
//   sat_cnt_clr : synchronous clear of the saturation counter
//   sat_cnt     : saturating count of clipped output transfers
module stoch_round_unit
    import stoch_round_pkg::*;
#(
    parameter int unsigned IN_W   = SR_IN_W_DEF,
    parameter int unsigned DROP_W = SR_RND_W,
    parameter int unsigned OUT_W  = IN_W - DROP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic [SR_RND_W-1:0] rnd,
    output logic                rnd_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat
`ifdef SR_SAT_CNT_EN
    ,
    input  logic                sat_cnt_clr,
    output logic [15:0]         sat_cnt
`endif
);

    if (DROP_W != SR_RND_W) begin : g_bad_drop_w
        $error("stoch_round_unit: DROP_W must equal the LFSR width (7)");
    end

    logic                s1_valid;
    logic [IN_W-1:0]     s1_data;
    logic [SR_RND_W-1:0] s1_rnd;
    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    logic [OUT_W-1:0]    core_res;
    logic                core_sat;

    // Handshake: stage 2 can take data when empty or draining.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !rst && (!s1_valid || s2_adv);
        accept   = in_valid && in_ready;
        rnd_en   = accept;
    end

    // Stage 1: capture word and its random sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_rnd   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_rnd   <= rnd;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    stoch_round_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data  (s1_data),
        .rnd   (s1_rnd),
        .res_c (core_res),
        .sat_c (core_sat)
    );

    // Stage 2: registered result, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= core_res;
                out_sat  <= core_sat;
            end
        end
    end

`ifdef SR_SAT_CNT_EN
    // Count clipped output transfers; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stoch_round_unit.sv
// Self-checking bench for stoch_round_unit (default 16 -> 9 bit build).
module tb_stoch_round_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [6:0]  rnd;
    logic        rnd_en;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_data;
    logic        out_sat;
`ifdef SR_SAT_CNT_EN
    logic        sat_cnt_clr = 1'b0;
    logic [15:0] sat_cnt;
    int          sat_model = 0;
`endif

    stoch_round_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rnd       (rnd),
        .rnd_en    (rnd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef SR_SAT_CNT_EN
        ,
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] d;
        logic       s;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [6:0]  r;
        logic [8:0]  ed;
        logic        es;
    } vec_t;

    localparam int NVEC = 20;

    exp_t sbq[$];
    vec_t tbl[NVEC];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pop_cnt  = 0;
    int rnd_en_cnt = 0;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;
    int first_acc_cyc = -1;
    int last_acc_cyc  = -1;
    bit saw_stall = 1'b0;

    logic       stall_prev = 1'b0;
    logic [8:0] held_d;
    logic       held_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: floor((x + r) / 128), clipped at +255.
    function automatic exp_t model(input logic [15:0] d, input logic [6:0] r);
        int   s;
        exp_t e;
        s = int'($signed(d)) + int'(r);
        s = s >>> 7;
        if (s > 255) begin
            e.d = 9'd255;
            e.s = 1'b1;
        end else begin
            e.d = 9'(s);
            e.s = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) cyc++;

    // Output monitor / scoreboard check, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            stall_prev = 1'b0;
`ifdef SR_SAT_CNT_EN
            sat_model = 0;
`endif
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_sat", 32'(out_sat), 32'(held_s));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_sat", 32'(out_sat), 32'(e.s));
`ifdef SR_SAT_CNT_EN
                    if (e.s && sat_model < 65535) sat_model++;
`endif
                end
                pop_cnt++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            held_d     = out_data;
            held_s     = out_sat;
            if (rnd_en) rnd_en_cnt++;
        end
    end

    // Present one word and hold it until accepted; pushes its expectation.
    task automatic send(input logic [15:0] d, input logic [6:0] r, input exp_t e);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        rnd      = r;
        #1;
        while (!in_ready) begin
            saw_stall = 1'b1;
            guard++;
            if (guard > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%0h", d);
                return;
            end
            @(negedge clk);
            #1;
        end
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk(name, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   p0;
        int   r0;
        exp_t e;

        tbl[0] = '{16'h0040, 7'h3F, 9'h000, 1'b0};
        tbl[1] = '{16'h0040, 7'h40, 9'h001, 1'b0};
        tbl[2] = '{16'h7FFF, 7'h01, 9'h0FF, 1'b1};
        tbl[3] = '{16'h7FFF, 7'h00, 9'h0FF, 1'b0};
        tbl[4] = '{16'hFF80, 7'h7F, 9'h1FF, 1'b0};
        tbl[5] = '{16'hFFC0, 7'h40, 9'h000, 1'b0};
        tbl[6] = '{16'h8000, 7'h00, 9'h100, 1'b0};
        for (int i = 7; i < NVEC; i++) begin
            tbl[i].din = 16'($urandom);
            tbl[i].r   = 7'($urandom_range(0, 127));
            e = model(tbl[i].din, tbl[i].r);
            tbl[i].ed = e.d;
            tbl[i].es = e.s;
        end

        // Reset state, with in_valid high to prove rnd_en is gated.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        rnd       = 7'h11;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rnd_en", 32'(rnd_en), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Table vectors, back to back.
        for (int i = 0; i < NVEC; i++) begin
            e.d = tbl[i].ed;
            e.s = tbl[i].es;
            send(tbl[i].din, tbl[i].r, e);
        end
        idle();
        wait_drain("table_drain");

        // Throughput and latency.
        p0 = pop_cnt;
        r0 = rnd_en_cnt;
        first_out_cyc = -1;
        first_acc_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            logic [6:0]  r;
            d = 16'($urandom);
            r = 7'($urandom_range(0, 127));
            send(d, r, model(d, r));
        end
        idle();
        wait_drain("tput_drain");
        chk("tput_count", 32'(pop_cnt - p0), 32'd8);
        chk("tput_rnd_en", 32'(rnd_en_cnt - r0), 32'd8);
        chk("tput_in_rate", 32'(last_acc_cyc - first_acc_cyc), 32'd7);
        chk("latency", 32'(first_out_cyc - first_acc_cyc), 32'd2);
        chk("tput_out_rate", 32'(last_out_cyc - first_out_cyc), 32'd7);

        // Backpressure: out_ready low for cycles 3..6 of an 8-word stream.
        p0 = pop_cnt;
        r0 = rnd_en_cnt;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] d;
                    logic [6:0]  r;
                    d = 16'($urandom);
                    r = 7'($urandom_range(0, 127));
                    send(d, r, model(d, r));
                end
                idle();
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 3 && c <= 6);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_count", 32'(pop_cnt - p0), 32'd8);
        chk("bp_rnd_en", 32'(rnd_en_cnt - r0), 32'd8);
        chk("bp_in_ready_drop", 32'(saw_stall), 32'd1);

        // Async reset with both stages full.
        out_ready = 1'b0;
        send(16'h1111, 7'h22, model(16'h1111, 7'h22));
        send(16'h2222, 7'h33, model(16'h2222, 7'h33));
        @(negedge clk);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_rnd_en", 32'(rnd_en), 32'd0);
        sbq.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        p0 = pop_cnt;
        send(16'h00C0, 7'h3F, '{9'h001, 1'b0});
        idle();
        wait_drain("post_rst_drain");
        chk("post_rst_count", 32'(pop_cnt - p0), 32'd1);

`ifdef SR_SAT_CNT_EN
        chk("sat_cnt", 32'(sat_cnt), 32'(sat_model));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
